// File: rtl/ase_pcie_ss_cpl_splitter_pkg.sv
// rtl/ase_pcie_ss_cpl_splitter_pkg.sv - shared types and chunk-length helper for the completion splitter
package ase_pcie_ss_cpl_splitter_pkg;

    localparam int unsigned CPL_LEN_W  = 13;
    localparam int unsigned CPL_TAG_W  = 10;
    localparam int unsigned CPL_ADDR_W = 64;

    typedef logic [CPL_LEN_W-1:0] t_cpl_len;

    typedef struct packed {
        logic [CPL_TAG_W-1:0]  tag;
        logic [CPL_ADDR_W-1:0] addr;
        logic [CPL_LEN_W-1:0]  len;
    } t_ase_pcie_ss_rd_req;

    typedef struct packed {
        logic [CPL_TAG_W-1:0]  tag;
        logic [CPL_ADDR_W-1:0] addr;
        logic [CPL_LEN_W-1:0]  len;
        logic [CPL_LEN_W-1:0]  byte_count;
        logic [6:0]            lower_addr;
        logic                  last;
    } t_ase_pcie_ss_cpl_chunk;

    // Room to the next RCB-aligned cap, clipped by what is left of the request.
    function automatic t_cpl_len ase_pcie_ss_cpl_chunk_len(
        input t_cpl_len addr_low,
        input t_cpl_len rem,
        input t_cpl_len rcb,
        input t_cpl_len max_cpl
    );
        t_cpl_len room;
        room = max_cpl - (addr_low & (rcb - t_cpl_len'(1)));
        return (rem < room) ? rem : room;
    endfunction

endpackage

// File: rtl/ase_pcie_ss_cpl_splitter_if.sv
// rtl/ase_pcie_ss_cpl_splitter_if.sv - request and completion-chunk handshake bundle
interface ase_pcie_ss_cpl_splitter_if #(
    parameter int unsigned TAG_WIDTH  = 10,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 13
);
    logic                  req_valid;
    logic                  req_ready;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;

    logic                  cpl_valid;
    logic                  cpl_ready;
    logic [TAG_WIDTH-1:0]  cpl_tag;
    logic [ADDR_WIDTH-1:0] cpl_addr;
    logic [LEN_WIDTH-1:0]  cpl_len;
    logic [LEN_WIDTH-1:0]  cpl_byte_count;
    logic [6:0]            cpl_lower_addr;
    logic                  cpl_last;

    modport master (
        output req_valid, req_tag, req_addr, req_len, cpl_ready,
        input  req_ready, cpl_valid, cpl_tag, cpl_addr, cpl_len,
               cpl_byte_count, cpl_lower_addr, cpl_last
    );

    modport slave (
        input  req_valid, req_tag, req_addr, req_len, cpl_ready,
        output req_ready, cpl_valid, cpl_tag, cpl_addr, cpl_len,
               cpl_byte_count, cpl_lower_addr, cpl_last
    );
endinterface

// File: rtl/ase_pcie_ss_cpl_splitter.sv
// rtl/ase_pcie_ss_cpl_splitter.sv - splits one DMA read request into RCB-aligned completion chunks
module ase_pcie_ss_cpl_splitter
    import ase_pcie_ss_cpl_splitter_pkg::*;
#(
    parameter int unsigned RCB_BYTES        = 64,
    parameter int unsigned MAX_CPL_BYTES    = 128,
    parameter int unsigned MAX_RD_REQ_BYTES = 512,
    parameter int unsigned TAG_WIDTH        = 10,
    parameter int unsigned ADDR_WIDTH       = 64,
    parameter int unsigned LEN_WIDTH        = 13
) (
    input  logic                          clk,
    input  logic                          reset,
    ase_pcie_ss_cpl_splitter_if.slave     bus,
    output logic                          err_valid,
    output logic [TAG_WIDTH-1:0]          err_tag,
    output logic                          busy
);

    if (!(RCB_BYTES == 64 || RCB_BYTES == 128)) begin : g_bad_rcb
        $error("RCB_BYTES must be 64 or 128");
    end
    if ((MAX_CPL_BYTES % RCB_BYTES) != 0 || MAX_CPL_BYTES == 0 || MAX_CPL_BYTES > MAX_RD_REQ_BYTES) begin : g_bad_max_cpl
        $error("MAX_CPL_BYTES must be a nonzero multiple of RCB_BYTES and not exceed MAX_RD_REQ_BYTES");
    end
    if (MAX_RD_REQ_BYTES > 4096) begin : g_bad_max_rd
        $error("MAX_RD_REQ_BYTES must not exceed 4096");
    end
    if (LEN_WIDTH != CPL_LEN_W || ADDR_WIDTH < 12) begin : g_bad_width
        $error("LEN_WIDTH must be 13 and ADDR_WIDTH at least 12");
    end

    typedef enum logic {S_IDLE, S_SPLIT} t_state;

    t_state                state_q, state_d;
    logic [TAG_WIDTH-1:0]  cur_tag_q, cur_tag_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  err_valid_q, err_valid_d;
    logic [TAG_WIDTH-1:0]  err_tag_q, err_tag_d;

    logic                  split;
    logic [LEN_WIDTH-1:0]  chunk_len;
    logic                  chunk_last;
    logic                  req_fire;
    logic                  req_bad;
    logic [LEN_WIDTH-1:0]  end_off;

    assign split      = (state_q == S_SPLIT);
    assign chunk_len  = ase_pcie_ss_cpl_chunk_len(t_cpl_len'(cur_addr_q[11:0]), rem_q,
                                                  t_cpl_len'(RCB_BYTES), t_cpl_len'(MAX_CPL_BYTES));
    assign chunk_last = split && (chunk_len == rem_q);

    // Offset within the 4 KB page after the request; anything past 4096 crosses a page.
    assign end_off = LEN_WIDTH'(bus.req_addr[11:0]) + bus.req_len;
    assign req_bad = (bus.req_len == '0)
                  || (bus.req_len > LEN_WIDTH'(MAX_RD_REQ_BYTES))
                  || (bus.req_len[1:0] != 2'b00)
                  || (bus.req_addr[1:0] != 2'b00)
                  || (end_off > LEN_WIDTH'(4096));

    // Ready also opens on the final chunk handshake so requests stream without a bubble.
    assign bus.req_ready = !reset && (!split || (bus.cpl_ready && chunk_last));
    assign req_fire      = bus.req_valid && bus.req_ready;

    assign bus.cpl_valid      = split;
    assign bus.cpl_tag        = split ? cur_tag_q : '0;
    assign bus.cpl_addr       = split ? cur_addr_q : '0;
    assign bus.cpl_len        = split ? chunk_len : '0;
    assign bus.cpl_byte_count = split ? rem_q : '0;
    assign bus.cpl_lower_addr = split ? cur_addr_q[6:0] : 7'd0;
    assign bus.cpl_last       = chunk_last;

    assign err_valid = err_valid_q;
    assign err_tag   = err_tag_q;
    assign busy      = split;

    always_comb begin
        state_d     = state_q;
        cur_tag_d   = cur_tag_q;
        cur_addr_d  = cur_addr_q;
        rem_d       = rem_q;
        err_valid_d = 1'b0;
        err_tag_d   = err_tag_q;

        if (split && bus.cpl_ready) begin
            if (chunk_last) begin
                state_d = S_IDLE;
            end else begin
                cur_addr_d = cur_addr_q + ADDR_WIDTH'(chunk_len);
                rem_d      = rem_q - chunk_len;
            end
        end

        if (req_fire) begin
            if (req_bad) begin
                err_valid_d = 1'b1;
                err_tag_d   = bus.req_tag;
            end else begin
                state_d    = S_SPLIT;
                cur_tag_d  = bus.req_tag;
                cur_addr_d = bus.req_addr;
                rem_d      = bus.req_len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_tag_q   <= '0;
            cur_addr_q  <= '0;
            rem_q       <= '0;
            err_valid_q <= 1'b0;
            err_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_tag_q   <= cur_tag_d;
            cur_addr_q  <= cur_addr_d;
            rem_q       <= rem_d;
            err_valid_q <= err_valid_d;
            err_tag_q   <= err_tag_d;
        end
    end

endmodule

// File: tb/tb_ase_pcie_ss_cpl_splitter.sv
// tb/tb_ase_pcie_ss_cpl_splitter.sv - scoreboard bench for the completion splitter
module tb_ase_pcie_ss_cpl_splitter;
    import ase_pcie_ss_cpl_splitter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic err_valid;
    logic [9:0] err_tag;
    logic busy;

    int checks = 0;
    int errors = 0;

    t_ase_pcie_ss_cpl_chunk exp_cpl[$];
    logic [9:0]             exp_err[$];

    ase_pcie_ss_cpl_splitter_if #(.TAG_WIDTH(10), .ADDR_WIDTH(64), .LEN_WIDTH(13)) bus ();

    ase_pcie_ss_cpl_splitter #(
        .RCB_BYTES(64), .MAX_CPL_BYTES(128), .MAX_RD_REQ_BYTES(512),
        .TAG_WIDTH(10), .ADDR_WIDTH(64), .LEN_WIDTH(13)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .err_valid(err_valid), .err_tag(err_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_cpl(input logic [9:0] tag, input logic [63:0] addr, input logic [12:0] len,
                            input logic [12:0] bc, input logic [6:0] lower, input logic last);
        t_ase_pcie_ss_cpl_chunk c;
        c.tag = tag; c.addr = addr; c.len = len;
        c.byte_count = bc; c.lower_addr = lower; c.last = last;
        exp_cpl.push_back(c);
    endtask

    // Called just after a posedge; returns just after the posedge following the latency check.
    task automatic send(input logic [9:0] tag, input logic [63:0] addr, input logic [12:0] len,
                        input bit good, input bit with_last);
        int  n;
        bit  acc_last;
        bus.req_valid = 1'b1;
        bus.req_tag   = tag;
        bus.req_addr  = addr;
        bus.req_len   = len;
        if (!good) exp_err.push_back(tag);
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++; errors++;
            $display("FAIL req_accept_timeout: tag 0x%0h not accepted within 200 cycles", tag);
        end
        acc_last = bus.cpl_valid && bus.cpl_last && bus.cpl_ready;
        if (with_last) check("accept_with_last_chunk", 64'(acc_last), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        if (good) begin
            check("first_chunk_latency", 64'(bus.cpl_valid), 64'd1);
            check("first_chunk_tag", 64'(bus.cpl_tag), 64'(tag));
        end else begin
            check("err_latency", 64'(err_valid), 64'd1);
            check("no_chunk_on_err", 64'(bus.cpl_valid), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_cpl.size() != 0 || exp_err.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_cpl.size() != 0 || exp_err.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d chunks and %0d errors still expected", exp_cpl.size(), exp_err.size());
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    t_ase_pcie_ss_cpl_chunk held;
    bit stall_q = 1'b0;
    always @(negedge clk) begin
        t_ase_pcie_ss_cpl_chunk act, e;
        act.tag = bus.cpl_tag; act.addr = bus.cpl_addr; act.len = bus.cpl_len;
        act.byte_count = bus.cpl_byte_count; act.lower_addr = bus.cpl_lower_addr; act.last = bus.cpl_last;
        if (!reset) begin
            if (stall_q && bus.cpl_valid) begin
                checks++;
                if (act !== held) begin
                    errors++;
                    $display("FAIL stall_stable: addr 0x%0h len %0d bc %0d vs held addr 0x%0h len %0d bc %0d",
                             act.addr, act.len, act.byte_count, held.addr, held.len, held.byte_count);
                end
            end
            if (bus.cpl_valid && bus.cpl_ready) begin
                checks++;
                if (exp_cpl.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_chunk: addr 0x%0h len %0d", act.addr, act.len);
                end else begin
                    e = exp_cpl.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL chunk: got tag 0x%0h addr 0x%0h len %0d bc %0d lower 0x%0h last %0d expected tag 0x%0h addr 0x%0h len %0d bc %0d lower 0x%0h last %0d",
                                 act.tag, act.addr, act.len, act.byte_count, act.lower_addr, act.last,
                                 e.tag, e.addr, e.len, e.byte_count, e.lower_addr, e.last);
                    end
                end
            end
            if (err_valid) begin
                checks++;
                if (exp_err.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_err: tag 0x%0h", err_tag);
                end else if (err_tag !== exp_err[0]) begin
                    errors++;
                    $display("FAIL err_tag: got 0x%0h expected 0x%0h", err_tag, exp_err[0]);
                    void'(exp_err.pop_front());
                end else begin
                    void'(exp_err.pop_front());
                end
            end
        end
        stall_q <= bus.cpl_valid && !bus.cpl_ready;
        held    <= act;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_tag = '0; bus.req_addr = '0; bus.req_len = '0;
        bus.cpl_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 64'(bus.req_ready), 64'd0);
        check("reset_cpl_valid", 64'(bus.cpl_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_err_valid", 64'(err_valid), 64'd0);
        check("reset_cpl_addr", bus.cpl_addr, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Unaligned start: 112 B to the boundary then the 88 B remainder.
        push_cpl(10'h001, 64'h1010, 13'd112, 13'd200, 7'h10, 1'b0);
        push_cpl(10'h001, 64'h1080, 13'd88,  13'd88,  7'h00, 1'b1);
        send(10'h001, 64'h1010, 13'd200, 1'b1, 1'b0);
        drain(50);

        push_cpl(10'h002, 64'h2000, 13'd128, 13'd512, 7'h00, 1'b0);
        push_cpl(10'h002, 64'h2080, 13'd128, 13'd384, 7'h00, 1'b0);
        push_cpl(10'h002, 64'h2100, 13'd128, 13'd256, 7'h00, 1'b0);
        push_cpl(10'h002, 64'h2180, 13'd128, 13'd128, 7'h00, 1'b1);
        send(10'h002, 64'h2000, 13'd512, 1'b1, 1'b0);
        drain(50);

        // Ends exactly at the 4 KB page edge: legal.
        push_cpl(10'h003, 64'h0FE0, 13'd32, 13'd32, 7'h60, 1'b1);
        send(10'h003, 64'h0FE0, 13'd32, 1'b1, 1'b0);
        drain(50);

        send(10'h011, 64'h3000, 13'd0,   1'b0, 1'b0);
        send(10'h012, 64'h3000, 13'd516, 1'b0, 1'b0);
        send(10'h013, 64'h3002, 13'd64,  1'b0, 1'b0);
        send(10'h014, 64'h0FF0, 13'd32,  1'b0, 1'b0);
        send(10'h015, 64'h3000, 13'd6,   1'b0, 1'b0);
        drain(50);
        check("idle_after_errors", 64'(busy), 64'd0);

        // Downstream stall for five cycles on the first chunk.
        push_cpl(10'h020, 64'h4040, 13'd128, 13'd256, 7'h40, 1'b0);
        push_cpl(10'h020, 64'h40C0, 13'd128, 13'd128, 7'h40, 1'b1);
        bus.cpl_ready = 1'b0;
        send(10'h020, 64'h4040, 13'd256, 1'b1, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        bus.cpl_ready = 1'b1;
        drain(50);

        // Second request must be accepted alongside the first's last chunk.
        push_cpl(10'h005, 64'h6020, 13'd96, 13'd160, 7'h20, 1'b0);
        push_cpl(10'h005, 64'h6080, 13'd64, 13'd64,  7'h00, 1'b1);
        push_cpl(10'h006, 64'h7000, 13'd64, 13'd64,  7'h00, 1'b1);
        send(10'h005, 64'h6020, 13'd160, 1'b1, 1'b0);
        send(10'h006, 64'h7000, 13'd64,  1'b1, 1'b1);
        drain(50);

        // Reset while the second of four chunks is presented.
        push_cpl(10'h007, 64'h5000, 13'd128, 13'd512, 7'h00, 1'b0);
        send(10'h007, 64'h5000, 13'd512, 1'b1, 1'b0);
        bus.cpl_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.cpl_ready = 1'b1;
        @(negedge clk);
        check("reset_mid_cpl_valid", 64'(bus.cpl_valid), 64'd0);
        check("reset_mid_busy", 64'(busy), 64'd0);
        check("reset_mid_first_chunk_seen", 64'(exp_cpl.size()), 64'd0);
        @(posedge clk); #1;
        push_cpl(10'h009, 64'h5100, 13'd64, 13'd64, 7'h00, 1'b1);
        send(10'h009, 64'h5100, 13'd64, 1'b1, 1'b0);
        drain(50);
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ase_pcie_ss_cpl_splitter.md
# ase_pcie_ss_cpl_splitter

Splits one accepted DMA read request into the ordered sequence of completion chunks that the ASE PCIe SS host model returns to the AFU. Each chunk is at most MAX_CPL_BYTES, and every chunk except the last ends on a request-completion-boundary. The block sits between the host-memory read request decoder (upstream) and the completion TLP encoder (downstream). Its parameters are set from the ASE PCIe SS parameter configuration fields `request_completion_boundary` and `max_rd_req_bytes`.

## Interface
- RCB_BYTES, 64, completion boundary in bytes; must be 64 or 128.
- MAX_CPL_BYTES, 128, maximum payload per chunk; must be a multiple of RCB_BYTES and ≤ MAX_RD_REQ_BYTES.
- MAX_RD_REQ_BYTES, 512, largest legal request; must be ≤ 4096.
- TAG_WIDTH, 10, request tag width.
- ADDR_WIDTH, 64, byte address width.
- LEN_WIDTH, 13, byte length width; covers 0..4096.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_tag  in  TAG_WIDTH  request tag.
- req_addr  in  ADDR_WIDTH  start byte address.
- req_len  in  LEN_WIDTH  request length in bytes.
- cpl_valid  out  1  chunk offered.
- cpl_ready  in  1  downstream accepts chunk.
- cpl_tag  out  TAG_WIDTH  tag of owning request.
- cpl_addr  out  ADDR_WIDTH  chunk start address.
- cpl_len  out  LEN_WIDTH  chunk payload bytes.
- cpl_byte_count  out  LEN_WIDTH  bytes remaining, including this chunk (PCIe byte-count semantics).
- cpl_lower_addr  out  7  cpl_addr[6:0].
- cpl_last  out  1  final chunk of the request.
- err_valid  out  1  one-cycle pulse: a malformed request was dropped.
- err_tag  out  TAG_WIDTH  tag of the dropped request.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE and SPLIT.
- Registers: cur_tag, cur_addr, rem.
- Request checks, evaluated on accept. A request is bad if any of the following hold:
  - req_len == 0;
  - req_len > MAX_RD_REQ_BYTES;
  - req_len[1:0] != 0;
  - req_addr[1:0] != 0;
  - req_addr[11:0] + req_len > 4096 (4 KB crossing).
- Good request: load cur_tag, cur_addr and rem = req_len, then go to SPLIT.
- Bad request: stay in IDLE, assert err_valid with err_tag the following cycle, emit no chunk.
- Chunk length: len = min(rem, MAX_CPL_BYTES − (cur_addr mod RCB_BYTES)).
  - The mod operation uses the low log2(RCB_BYTES) address bits.
  - All arithmetic is LEN_WIDTH-wide.
- In SPLIT, outputs are driven from registers plus the combinational len:
  - cpl_valid = 1;
  - cpl_byte_count = rem;
  - cpl_last = (len == rem).
- On a chunk handshake:
  - if cpl_last, go to IDLE;
  - otherwise cur_addr += len and rem −= len.
- Chunks are emitted strictly in address order. Requests are completed in acceptance order.

## Timing
- Reset values: req_ready 0 while reset is high; state IDLE; cpl_valid, err_valid and busy 0; all data outputs 0.
- req_ready = (state == IDLE) || (cpl_valid && cpl_ready && cpl_last). This path is combinational from cpl_ready, which allows back-to-back requests with no bubble.
- Latency:
  - request accepted in cycle N → first cpl_valid in cycle N+1;
  - bad request accepted in cycle N → err_valid in cycle N+1.
- While cpl_valid is high and cpl_ready is low, all cpl_* outputs hold stable.
- Throughput is one chunk per cycle when cpl_ready is held high.
- Simultaneous last-chunk handshake and new request: the new request's first chunk appears in the next cycle.
- Reset asserted mid-request: the in-flight request is discarded; outputs return to reset values in the next cycle; no further chunks are produced.
- Wrap-around: none. 4 KB crossing is rejected, so cur_addr never carries past bit 11 within a request.

## Structure
- ase_pcie_ss_pkg gains:
  - t_ase_pcie_ss_rd_req (tag, addr, len);
  - t_ase_pcie_ss_cpl_chunk (tag, addr, len, byte_count, lower_addr, last);
  - function ase_pcie_ss_cpl_chunk_len(addr_low, rem, rcb, max_cpl).
- Single module, no sub-module.
- Parameter legality is checked by elaboration-time assertions.

## Test plan
- addr 0x1010, len 200, RCB 64, MAX 128 → two chunks:
  - (0x1010, 112, bc 200, lower 0x10, last 0);
  - (0x1080, 88, bc 88, lower 0x00, last 1).
- addr 0x2000, len 512 → four 128 B chunks with bc 512/384/256/128; last set on the fourth only.
- len 0, len 516, addr 0x3002, and addr 0x0FF0 with len 32 → each accepted; err_valid one cycle later with the matching tag; no cpl_valid.
- cpl_ready held low 5 cycles mid-request → outputs stable; resumes with the correct next chunk.
- Two requests back-to-back with cpl_ready=1 → the second request is accepted in the same cycle as the first's last chunk; no idle cycle between them.
- Reset pulsed during the second chunk of a 4-chunk request → cpl_valid 0 next cycle; a fresh request afterward completes correctly.
